// File: rtl/bus_arbiter_rr.sv
// Round-robin system bus arbiter: one-hot registered grant, transaction framing,
// begin timeout and transaction watchdog with forced termination on the owner's behalf.
module bus_arbiter_rr #(
  parameter int nrOfMasters    = 4,
  parameter int beginTimeout   = 16,
  parameter int watchdogCycles = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nrOfMasters-1:0] requestBus,
  output logic [nrOfMasters-1:0] busGrant,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   busErrorIn,
  output logic                   endTransactionOut,
  output logic                   busErrorOut,
  output logic [2:0]             activeMaster,
  output logic                   busIdle
);

  localparam int BW = $clog2(beginTimeout + 1);
  localparam int WW = $clog2(watchdogCycles + 1);
  localparam logic [BW-1:0] BEG_LAST = BW'(beginTimeout - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(watchdogCycles - 1);
  localparam logic [2:0]    PTR_RST  = 3'(nrOfMasters - 1);

  typedef enum logic [2:0] {IDLE, GRANT, BUSY, FORCE_END, TURNAROUND} state_e;

  state_e                 state_q, state_d;
  logic [nrOfMasters-1:0] grant_q, grant_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [BW-1:0]          begCnt_q, begCnt_d;
  logic [WW-1:0]          wdCnt_q, wdCnt_d;
  logic                   endOut_q, endOut_d;
  logic                   errOut_q, errOut_d;

  // Slave bus errors are reported elsewhere; the arbiter only observes framing.
  logic unusedBusError;
  assign unusedBusError = busErrorIn;

  // Round-robin pick: lowest requester above the pointer wins, else lowest at/below it.
  logic [2:0]             sel;
  logic [nrOfMasters-1:0] selOh;
  always_comb begin
    sel   = ptr_q;
    selOh = '0;
    for (int j = nrOfMasters - 1; j >= 0; j--) begin
      if (requestBus[j] && (3'(j) <= ptr_q)) begin
        sel      = 3'(j);
        selOh    = '0;
        selOh[j] = 1'b1;
      end
    end
    for (int j = nrOfMasters - 1; j >= 0; j--) begin
      if (requestBus[j] && (3'(j) > ptr_q)) begin
        sel      = 3'(j);
        selOh    = '0;
        selOh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    begCnt_d = begCnt_q;
    wdCnt_d  = wdCnt_q;
    endOut_d = 1'b0;
    errOut_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|requestBus) begin
          grant_d  = selOh;
          ptr_d    = sel;
          begCnt_d = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (beginTransactionIn) begin
          wdCnt_d = '0;
          state_d = BUSY;
        end else if (begCnt_q == BEG_LAST) begin
          grant_d  = '0;
          errOut_d = 1'b1;
          state_d  = TURNAROUND;
        end else if (begCnt_q != '1) begin
          begCnt_d = begCnt_q + 1'b1;
        end
      end
      BUSY: begin
        // A genuine end on the expiry cycle takes priority over the watchdog.
        if (endTransactionIn) begin
          grant_d = '0;
          state_d = TURNAROUND;
        end else if (wdCnt_q == WD_LAST) begin
          grant_d  = '0;
          endOut_d = 1'b1;
          errOut_d = 1'b1;
          state_d  = FORCE_END;
        end else if (wdCnt_q != '1) begin
          wdCnt_d = wdCnt_q + 1'b1;
        end
      end
      FORCE_END:  state_d = TURNAROUND;
      TURNAROUND: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= PTR_RST;
      begCnt_q <= '0;
      wdCnt_q  <= '0;
      endOut_q <= 1'b0;
      errOut_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      begCnt_q <= begCnt_d;
      wdCnt_q  <= wdCnt_d;
      endOut_q <= endOut_d;
      errOut_q <= errOut_d;
    end
  end

  assign busGrant          = grant_q;
  assign endTransactionOut = endOut_q;
  assign busErrorOut       = errOut_q;
  assign activeMaster      = ptr_q;
  assign busIdle           = (state_q == IDLE);

endmodule
